// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 op encodings, FSM state encodings, default width and op helpers.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // funct3[2] separates the divide group from the multiply group
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic op_is_mulh(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of a pair of values. Used on the
// request side to turn signed operands into magnitudes and on the result
// side to restore the sign of product/quotient and remainder.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic         i_neg_a,
    input  logic [W-1:0] i_b,
    input  logic         i_neg_b,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    function automatic logic [W-1:0] cond_neg(input logic [W-1:0] val, input logic neg);
        logic signed [W-1:0] s_val;
        s_val = $signed(val);
        return neg ? $unsigned(-s_val) : val;
    endfunction

    assign o_a = cond_neg(i_a, i_neg_a);
    assign o_b = cond_neg(i_b, i_neg_b);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage. One bit per cycle:
// shift-add multiply into a 2*XLEN product, restoring shift-subtract divide.
// Divide-by-zero and signed overflow complete in one cycle.
// Optional build macro FAST_MUL_EN: multiplies are done combinationally at
// acceptance and also complete in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state;
    md_state_e         w_state_next;
    logic [2:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_in_div;
    logic              w_in_neg1;
    logic              w_in_neg2;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_short;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic [XLEN-1:0]   w_short_res;

    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic              w_last;

    logic [2*XLEN-1:0] w_iter_a;
    logic [2*XLEN-1:0] w_iter_b;
    logic [2*XLEN-1:0] w_fix_in_a;
    logic              w_fix_neg_a;
    logic              w_fix_neg_b;
    logic [2:0]        w_fix_op;
    logic [2*XLEN-1:0] w_fix_a;
    logic [2*XLEN-1:0] w_fix_b;
    logic [XLEN-1:0]   w_fix_res;

    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op,
                                                   input logic [2*XLEN-1:0] a,
                                                   input logic [2*XLEN-1:0] b);
        if (op_is_mulh(op)) return a[2*XLEN-1:XLEN];
        if (op_is_rem(op))  return b[XLEN-1:0];
        return a[XLEN-1:0];
    endfunction

    // RISC-V defined results for divide-by-zero and signed overflow
    function automatic logic [XLEN-1:0] special_result(input logic [2:0] op,
                                                       input logic zero,
                                                       input logic [XLEN-1:0] op1);
        if (zero) return op_is_rem(op) ? op1 : '1;
        return op_is_rem(op) ? '0 : op1;
    endfunction

    // Request-side classification and magnitude conversion
    assign w_in_div   = op_is_div(i_op);
    assign w_in_neg1  = op1_signed(i_op) && i_op1[XLEN-1];
    assign w_in_neg2  = op2_signed(i_op) && i_op2[XLEN-1];
    assign w_div_zero = w_in_div && (i_op2 == '0);
    assign w_div_ovf  = w_in_div && op1_signed(i_op) && (i_op1 == MOST_NEG) && (i_op2 == '1);

    muldiv_signfix #(.W(XLEN)) u_in_fix (
        .i_a     (i_op1),
        .i_neg_a (w_in_neg1),
        .i_b     (i_op2),
        .i_neg_b (w_in_neg2),
        .o_a     (w_mag1),
        .o_b     (w_mag2)
    );

    // One iteration step; r_acc holds {hi, lo} for both algorithms
    assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand};
    assign w_mul_next = r_acc[0] ? {w_add, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_mcand};
    // partial remainder stays below the divisor, so the borrow bit is the compare
    assign w_ge       = ~w_diff[XLEN];
    assign w_div_next = w_ge ? {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                             : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    assign w_acc_next = op_is_div(r_op) ? w_div_next : w_mul_next;
    assign w_last     = (r_cnt == CNT_W'(XLEN - 1));

    assign w_iter_a = op_is_div(r_op) ? {{XLEN{1'b0}}, w_acc_next[XLEN-1:0]} : w_acc_next;
    assign w_iter_b = {{XLEN{1'b0}}, w_acc_next[2*XLEN-1:XLEN]};

`ifdef FAST_MUL_EN
    logic              w_fast_mode;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_fast_mode = (r_state == IDLE);
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fix_in_a  = w_fast_mode ? w_fast_prod : w_iter_a;
    assign w_fix_neg_a = w_fast_mode ? (w_in_neg1 ^ w_in_neg2) : r_neg_a;
    assign w_fix_neg_b = w_fast_mode ? w_in_neg1 : r_neg_b;
    assign w_fix_op    = w_fast_mode ? i_op : r_op;
    assign w_short     = w_in_div ? (w_div_zero || w_div_ovf) : 1'b1;
    assign w_short_res = w_in_div ? special_result(i_op, w_div_zero, i_op1) : w_fix_res;
`else
    assign w_fix_in_a  = w_iter_a;
    assign w_fix_neg_a = r_neg_a;
    assign w_fix_neg_b = r_neg_b;
    assign w_fix_op    = r_op;
    assign w_short     = w_div_zero || w_div_ovf;
    assign w_short_res = special_result(i_op, w_div_zero, i_op1);
`endif

    muldiv_signfix #(.W(2*XLEN)) u_out_fix (
        .i_a     (w_fix_in_a),
        .i_neg_a (w_fix_neg_a),
        .i_b     (w_iter_b),
        .i_neg_b (w_fix_neg_b),
        .o_a     (w_fix_a),
        .o_b     (w_fix_b)
    );

    assign w_fix_res = sel_result(w_fix_op, w_fix_a, w_fix_b);
    assign o_result  = r_result;

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state, handshake and result-valid decode
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready  = !i_flush;
                w_accept = i_valid && !i_flush;
                if (w_accept) w_state_next = w_short ? DONE : BUSY;
            end
            BUSY: begin
                if (i_flush)     w_state_next = IDLE;
                else if (w_last) w_state_next = DONE;
            end
            DONE: begin
                o_valid      = !i_flush;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch, iteration and result register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= i_op;
            r_cnt   <= '0;
            r_mcand <= w_mag2;
            r_acc   <= {{XLEN{1'b0}}, w_mag1};
            r_neg_a <= w_in_neg1 ^ w_in_neg2;
            r_neg_b <= w_in_neg1;
            if (w_short) r_result <= w_short_res;
        end else if (r_state == BUSY && !i_flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= w_fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Issue one op, measure cycles from acceptance to o_valid, check result and pulse width.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat);
    int n;
    @(negedge i_clk);
    i_op = op; i_op1 = a; i_op2 = b; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    n = 1;
    @(negedge i_clk);
    if (lat > 1) begin
      n_assert++;
      if (o_ready !== 1'b0) begin n_fail++; $error("FAIL %s_busy_ready: observed %0h expected 0", tag, o_ready); end
    end
    while (o_valid !== 1'b1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    n_assert++;
    if (n !== lat) begin n_fail++; $error("FAIL %s_latency: observed %0d expected %0d", tag, n, lat); end
    n_assert++;
    if (o_result !== expv) begin n_fail++; $error("FAIL %s_result: observed %0h expected %0h", tag, o_result, expv); end
    @(negedge i_clk);
    n_assert++;
    if (o_valid !== 1'b0) begin n_fail++; $error("FAIL %s_pulse: observed %0h expected 0", tag, o_valid); end
    n_assert++;
    if (o_result !== expv) begin n_fail++; $error("FAIL %s_held: observed %0h expected %0h", tag, o_result, expv); end
    n_assert++;
    if (o_ready !== 1'b1) begin n_fail++; $error("FAIL %s_ready_after: observed %0h expected 1", tag, o_ready); end
  endtask

  initial begin
    int n;
    int seen;
    i_rst = 1'b1; i_valid = 1'b0; i_op = '0; i_op1 = '0; i_op2 = '0; i_flush = 1'b0;
    #12;
    n_assert++;
    if (o_ready !== 1'b1) begin n_fail++; $error("FAIL reset_ready: observed %0h", o_ready); end
    n_assert++;
    if (o_valid !== 1'b0) begin n_fail++; $error("FAIL reset_valid: observed %0h", o_valid); end
    n_assert++;
    if (o_result !== 32'h0) begin n_fail++; $error("FAIL reset_result: observed %0h", o_result); end
    @(negedge i_clk);
    i_rst = 1'b0;

    // multiply group
    run_op("mul_7x-3",   MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu_max",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_min",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhsu_m1",  MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mul_6x7",    MD_MUL,    32'd6,         32'd7,         32'd42,        MUL_LAT);

    // divide group
    run_op("div_-7/2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_-7/2",    MD_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100/7",  MD_DIVU,  32'd100,       32'd7,         32'd14,        DIV_LAT);
    run_op("remu_100/7",  MD_REMU,  32'd100,       32'd7,         32'd2,         DIV_LAT);
    run_op("divu_min/m1", MD_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DIV_LAT);

    // short-circuit corner cases
    run_op("divu_5/0",   MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_5/0",    MD_REM,    32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",    MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // flush in BUSY at cycle 10
    @(negedge i_clk);
    i_op = MD_DIV; i_op1 = 32'd1000; i_op2 = 32'd3; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    @(negedge i_clk);
    n_assert++;
    if (o_ready !== 1'b1) begin n_fail++; $error("FAIL flush_idle_ready: observed %0h", o_ready); end
    n_assert++;
    if (o_result !== 32'd0) begin n_fail++; $error("FAIL flush_result_kept: observed %0h", o_result); end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid === 1'b1) seen++;
      @(negedge i_clk);
    end
    n_assert++;
    if (seen !== 0) begin n_fail++; $error("FAIL flush_no_valid: observed %0d", seen); end

    // flush in IDLE blocks a same-cycle request
    i_op = MD_DIVU; i_op1 = 32'd9; i_op2 = 32'd0; i_valid = 1'b1; i_flush = 1'b1;
    #1;
    n_assert++;
    if (o_ready !== 1'b0) begin n_fail++; $error("FAIL idle_flush_ready_low: observed %0h", o_ready); end
    @(posedge i_clk);
    #1 i_valid = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    n_assert++;
    if (o_valid !== 1'b0) begin n_fail++; $error("FAIL idle_flush_not_accepted: observed %0h", o_valid); end
    n_assert++;
    if (o_result !== 32'd0) begin n_fail++; $error("FAIL idle_flush_result: observed %0h", o_result); end

    // result to be wiped by reset
    run_op("divu_99/3",  MD_DIVU,   32'd99,        32'd3,         32'd33,        DIV_LAT);

    // asynchronous reset mid-BUSY
    @(negedge i_clk);
    i_op = MD_DIVU; i_op1 = 32'd500; i_op2 = 32'd5; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    n_assert++;
    if (o_ready !== 1'b1) begin n_fail++; $error("FAIL arst_ready: observed %0h", o_ready); end
    n_assert++;
    if (o_valid !== 1'b0) begin n_fail++; $error("FAIL arst_valid: observed %0h", o_valid); end
    n_assert++;
    if (o_result !== 32'd0) begin n_fail++; $error("FAIL arst_result: observed %0h", o_result); end
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid === 1'b1) seen++;
      @(negedge i_clk);
    end
    n_assert++;
    if (seen !== 0) begin n_fail++; $error("FAIL arst_no_valid: observed %0d", seen); end

    // back-to-back with i_valid held high
    i_op = MD_DIVU; i_op1 = 32'd100; i_op2 = 32'd7; i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    n = 1;
    @(negedge i_clk);
    while (o_valid !== 1'b1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    n_assert++;
    if (n !== DIV_LAT) begin n_fail++; $error("FAIL b2b_first_latency: observed %0d", n); end
    n_assert++;
    if (o_result !== 32'd14) begin n_fail++; $error("FAIL b2b_first_result: observed %0h", o_result); end
    i_op = MD_REMU;
    @(negedge i_clk);
    n_assert++;
    if (o_ready !== 1'b1) begin n_fail++; $error("FAIL b2b_ready_next: observed %0h", o_ready); end
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    n = 1;
    @(negedge i_clk);
    n_assert++;
    if (o_ready !== 1'b0) begin n_fail++; $error("FAIL b2b_second_accepted: observed %0h", o_ready); end
    while (o_valid !== 1'b1 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    n_assert++;
    if (n !== DIV_LAT) begin n_fail++; $error("FAIL b2b_second_latency: observed %0d", n); end
    n_assert++;
    if (o_result !== 32'd2) begin n_fail++; $error("FAIL b2b_second_result: observed %0h", o_result); end

    @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
